// File: rtl/smart_traffic_light.sv
// Highway/local intersection controller with car-count driven
// left-turn and local phases and a registered phase countdown.
module smart_traffic_light #(
  parameter int HG_MIN        = 24,
  parameter int Y_TIME        = 4,
  parameter int LEFT_PER_CAR  = 6,
  parameter int LOCAL_PER_CAR = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] L,
  input  logic [2:0] H,
  output logic [2:0] RYG,
  output logic [3:0] LRYG,
  output logic [4:0] count_out
);

  typedef enum logic [2:0] {
    HG = 3'd0,
    HY = 3'd1,
    HL = 3'd2,
    LG = 3'd3,
    LY = 3'd4
  } state_t;

  localparam logic [4:0] HG_LD = 5'(HG_MIN - 1);
  localparam logic [4:0] Y_LD  = 5'(Y_TIME - 1);

  state_t     state;
  state_t     state_nx;
  logic [4:0] count_nx;
  logic [1:0] n_l;
  logic [1:0] n_h;
  logic       done;
  logic [4:0] left_ld;
  logic [4:0] local_ld;

  function automatic logic [1:0] pop3(input logic [2:0] v);
    return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction

  assign n_l      = pop3(L);
  assign n_h      = pop3(H);
  assign done     = (count_out == 5'd0);
  assign left_ld  = 5'(LEFT_PER_CAR * int'(n_h) - 1);
  assign local_ld = 5'(LOCAL_PER_CAR * int'(n_l) - 1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= HG;
      count_out <= HG_LD;
    end else begin
      state     <= state_nx;
      count_out <= count_nx;
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count_out - 5'd1;
    unique case (state)
      HG: begin
        if (done) begin
          count_nx = 5'd0;
          if (n_l != 2'd0 || n_h != 2'd0) begin
            state_nx = HY;
            count_nx = Y_LD;
          end
        end
      end
      HY: begin
        if (done) begin
          if (n_h != 2'd0) begin
            state_nx = HL;
            count_nx = left_ld;
          end else if (n_l != 2'd0) begin
            state_nx = LG;
            count_nx = local_ld;
          end else begin
            state_nx = HG;
            count_nx = HG_LD;
          end
        end
      end
      HL: begin
        if (done) begin
          if (n_l != 2'd0) begin
            state_nx = LG;
            count_nx = local_ld;
          end else begin
            state_nx = HG;
            count_nx = HG_LD;
          end
        end
      end
      LG: begin
        if (done) begin
          state_nx = LY;
          count_nx = Y_LD;
        end
      end
      LY: begin
        if (done) begin
          state_nx = HG;
          count_nx = HG_LD;
        end
      end
      default: begin
        state_nx = HG;
        count_nx = HG_LD;
      end
    endcase
  end

  // An illegal encoding shows highway-green lamps until it recovers.
  always_comb begin
    RYG  = 3'b001;
    LRYG = 4'b0100;
    unique case (state)
      HG: begin
        RYG  = 3'b001;
        LRYG = 4'b0100;
      end
      HY: begin
        RYG  = 3'b010;
        LRYG = 4'b0100;
      end
      HL: begin
        RYG  = 3'b100;
        LRYG = 4'b1100;
      end
      LG: begin
        RYG  = 3'b100;
        LRYG = 4'b0001;
      end
      LY: begin
        RYG  = 3'b100;
        LRYG = 4'b0010;
      end
      default: begin
        RYG  = 3'b001;
        LRYG = 4'b0100;
      end
    endcase
  end

endmodule

// File: tb/tb_smart_traffic_light.sv
// Bench for smart_traffic_light: vector table, corner sequences,
// and random demand against a phase-level reference model.
module tb_smart_traffic_light;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] L;
  logic [2:0] H;
  logic [2:0] RYG;
  logic [3:0] LRYG;
  logic [4:0] count_out;

  int checks = 0;
  int errors = 0;

  localparam int P_HG = 0;
  localparam int P_HY = 1;
  localparam int P_HL = 2;
  localparam int P_LG = 3;
  localparam int P_LY = 4;

  int m_ph;
  int m_dur;
  int m_el;
  bit m_valid = 1'b0;

  typedef struct {
    logic       rst;
    logic [2:0] l;
    logic [2:0] h;
    int         n;
    logic [2:0] ryg;
    logic [3:0] lryg;
    logic [4:0] cnt;
  } vec_t;

  vec_t vt[14];

  smart_traffic_light dut (
    .clk(clk),
    .reset(reset),
    .L(L),
    .H(H),
    .RYG(RYG),
    .LRYG(LRYG),
    .count_out(count_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int cars(input logic [2:0] v);
    return int'(v[0]) + int'(v[1]) + int'(v[2]);
  endfunction

  task automatic enter(input int ph, input int dur);
    m_ph  = ph;
    m_dur = dur;
    m_el  = 0;
  endtask

  task automatic model_step();
    int nl;
    int nh;
    nl = cars(L);
    nh = cars(H);
    if (!reset) begin
      enter(P_HG, 24);
      m_valid = 1'b1;
    end else if (m_el < m_dur - 1) begin
      m_el++;
    end else begin
      case (m_ph)
        P_HG: if (nl > 0 || nh > 0) enter(P_HY, 4);
              else m_el++;
        P_HY: if (nh > 0) enter(P_HL, 6 * nh);
              else if (nl > 0) enter(P_LG, 8 * nl);
              else enter(P_HG, 24);
        P_HL: if (nl > 0) enter(P_LG, 8 * nl);
              else enter(P_HG, 24);
        P_LG: enter(P_LY, 4);
        default: enter(P_HG, 24);
      endcase
    end
  endtask

  task automatic model_check();
    int e_ryg;
    int e_lryg;
    int e_cnt;
    bit inv;
    e_ryg  = (m_ph == P_HG) ? 1 : (m_ph == P_HY) ? 2 : 4;
    e_lryg = (m_ph == P_HL) ? 12 : (m_ph == P_LG) ? 1 :
             (m_ph == P_LY) ? 2 : 4;
    e_cnt  = m_dur - 1 - m_el;
    if (e_cnt < 0) e_cnt = 0;
    chk("model_ryg", int'(RYG), e_ryg);
    chk("model_lryg", int'(LRYG), e_lryg);
    chk("model_cnt", int'(count_out), e_cnt);
    inv = ($countones(RYG) == 1) && ($countones(LRYG[2:0]) == 1);
    if ((LRYG[0] || LRYG[1]) && RYG != 3'b100) inv = 1'b0;
    if (LRYG[3] && !(RYG == 3'b100 && LRYG[2])) inv = 1'b0;
    chk("safety", int'(inv), 1);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (m_valid) model_check();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expect_out(input string nm, input logic [2:0] ryg,
                            input logic [3:0] lryg, input logic [4:0] cnt);
    chk({nm, "_ryg"}, int'(RYG), int'(ryg));
    chk({nm, "_lryg"}, int'(LRYG), int'(lryg));
    chk({nm, "_cnt"}, int'(count_out), int'(cnt));
  endtask

  initial begin
    reset = 1'b0;
    L = 3'b000;
    H = 3'b000;

    vt[0]  = '{1'b0, 3'b000, 3'b000, 3,  3'b001, 4'b0100, 5'd23};
    vt[1]  = '{1'b1, 3'b000, 3'b000, 1,  3'b001, 4'b0100, 5'd22};
    vt[2]  = '{1'b1, 3'b000, 3'b000, 22, 3'b001, 4'b0100, 5'd0};
    vt[3]  = '{1'b1, 3'b000, 3'b000, 10, 3'b001, 4'b0100, 5'd0};
    vt[4]  = '{1'b1, 3'b000, 3'b100, 1,  3'b010, 4'b0100, 5'd3};
    vt[5]  = '{1'b1, 3'b000, 3'b100, 3,  3'b010, 4'b0100, 5'd0};
    vt[6]  = '{1'b1, 3'b000, 3'b100, 1,  3'b100, 4'b1100, 5'd5};
    vt[7]  = '{1'b1, 3'b000, 3'b000, 5,  3'b100, 4'b1100, 5'd0};
    vt[8]  = '{1'b1, 3'b000, 3'b000, 1,  3'b001, 4'b0100, 5'd23};
    vt[9]  = '{1'b1, 3'b100, 3'b000, 23, 3'b001, 4'b0100, 5'd0};
    vt[10] = '{1'b1, 3'b100, 3'b000, 1,  3'b010, 4'b0100, 5'd3};
    vt[11] = '{1'b1, 3'b100, 3'b000, 4,  3'b100, 4'b0001, 5'd7};
    vt[12] = '{1'b1, 3'b000, 3'b000, 8,  3'b100, 4'b0010, 5'd3};
    vt[13] = '{1'b1, 3'b000, 3'b000, 4,  3'b001, 4'b0100, 5'd23};

    #2;
    for (int i = 0; i < 14; i++) begin
      reset = vt[i].rst;
      L = vt[i].l;
      H = vt[i].h;
      run(vt[i].n);
      expect_out($sformatf("vec%0d", i), vt[i].ryg, vt[i].lryg, vt[i].cnt);
    end

    // Two left cars then three local cars.
    run(23);
    H = 3'b110;
    L = 3'b111;
    run(1);
    expect_out("big_hy", 3'b010, 4'b0100, 5'd3);
    run(4);
    expect_out("big_hl", 3'b100, 4'b1100, 5'd11);
    run(12);
    expect_out("big_lg", 3'b100, 4'b0001, 5'd23);
    run(24);
    expect_out("big_ly", 3'b100, 4'b0010, 5'd3);
    run(4);
    expect_out("big_hg", 3'b001, 4'b0100, 5'd23);

    // Local demand withdrawn mid-green keeps the fixed duration.
    H = 3'b000;
    L = 3'b110;
    run(24);
    expect_out("lg2_hy", 3'b010, 4'b0100, 5'd3);
    run(4);
    expect_out("lg2_entry", 3'b100, 4'b0001, 5'd15);
    L = 3'b000;
    run(15);
    expect_out("lg2_last", 3'b100, 4'b0001, 5'd0);
    run(1);
    expect_out("lg2_ly", 3'b100, 4'b0010, 5'd3);
    run(4);
    expect_out("lg2_hg", 3'b001, 4'b0100, 5'd23);

    // Reset in the middle of the left-arrow phase.
    H = 3'b100;
    run(28);
    expect_out("rst_hl", 3'b100, 4'b1100, 5'd5);
    H = 3'b000;
    run(2);
    reset = 1'b0;
    run(1);
    expect_out("rst_mid", 3'b001, 4'b0100, 5'd23);
    reset = 1'b1;

    // Random demand, non-thermometer codes included, rare resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(3) == 0) begin
        L = ($urandom_range(2) == 0) ? 3'($urandom) : 3'b000;
        H = ($urandom_range(2) == 0) ? 3'($urandom) : 3'b000;
      end
      reset = ($urandom_range(299) == 0) ? 1'b0 : 1'b1;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
